// File: rtl/multicycle_decode.sv
// Multicycle ARM main decoder: Moore FSM over FETCH..WB with ALU decode, PC-write logic and memory-wait fault trap.
// Optional MUL decode is enabled by defining DECODE_MUL_EN.
module multicycle_decode #(
  parameter int unsigned ALUC_W   = 3,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic [3:0]        Mul4,
  input  logic              MemRdy,
  output logic [1:0]        FlagW,
  output logic              PCS,
  output logic              NextPC,
  output logic              RegW,
  output logic              MemW,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic [1:0]        ResultSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              Fault
);

  localparam int unsigned CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] waitcnt_q;
  logic             fault_q;
  logic             rdy;
  logic             mem_state;
  logic             stalled;
  logic             timeout;
  logic             alu_op;
  logic             branch;
  logic             regw_raw;
  logic             memw_raw;
  logic [2:0]       alu_ctl;
  logic             is_addsub;

  assign rdy       = (MEM_WAIT != 0) ? MemRdy : 1'b1;
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign stalled   = mem_state && !rdy;
  assign timeout   = (WAIT_MAX != 0) && stalled && (waitcnt_q == CNT_W'(WAIT_MAX));
  assign Fault     = fault_q;

  // State, wait counter and sticky fault flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      waitcnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        waitcnt_q <= '0;
      end else if (stalled) begin
        waitcnt_q <= waitcnt_q + CNT_W'(1);
      end
      if (state_d == S_FAULT) begin
        fault_q <= 1'b1;
      end
    end
  end

  // Next-state sequencing; a memory timeout overrides the hold
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (rdy) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FAULT;
  end

  // Per-state datapath controls; write enables are suppressed while reset is held
  always_comb begin
    NextPC    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    alu_op    = 1'b0;
    branch    = 1'b0;
    regw_raw  = 1'b0;
    memw_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        NextPC    = rdy;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw_raw  = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        memw_raw = 1'b1;
      end
      S_EXECR: alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB: regw_raw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      NextPC   = 1'b0;
      IRWrite  = 1'b0;
      alu_op   = 1'b0;
      branch   = 1'b0;
      regw_raw = 1'b0;
      memw_raw = 1'b0;
    end
  end

  assign RegW   = regw_raw;
  assign MemW   = memw_raw;
  assign PCS    = branch || (regw_raw && (Rd == 4'hF));
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

  // ALU operation and flag-write decode from the function field
  always_comb begin
    alu_ctl   = ALU_ADD;
    is_addsub = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alu_ctl = ALU_ADD; is_addsub = 1'b1; end
      4'b0010: begin alu_ctl = ALU_SUB; is_addsub = 1'b1; end
      4'b0000: alu_ctl = ALU_AND;
      4'b1100: alu_ctl = ALU_ORR;
      4'b0001: alu_ctl = ALU_EOR;
      default: alu_ctl = ALU_ADD;
    endcase
`ifdef DECODE_MUL_EN
    if ((Op == 2'b00) && !Funct[5] && (Funct[4:1] == 4'b0000) && (Mul4 == 4'b1001)) begin
      alu_ctl = 3'b101;
    end
`endif
    if (!alu_op) begin
      alu_ctl   = ALU_ADD;
      is_addsub = 1'b0;
    end
  end

`ifndef DECODE_MUL_EN
  logic unused_mul4;
  assign unused_mul4 = ^Mul4;
`endif

  assign ALUControl = ALUC_W'(alu_ctl);
  assign FlagW[1]   = alu_op && Funct[0];
  assign FlagW[0]   = alu_op && Funct[0] && is_addsub;

endmodule

// File: tb/tb_multicycle_decode.sv
// Scoreboard bench for multicycle_decode: per-instruction phase model drives random instructions and memory stalls.
module tb_multicycle_decode;

  localparam int WAIT_LIMIT = 15;
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4, P_MEMWR = 5;
  localparam int P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9, P_FAULT = 10;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs, nextpc, regw, memw, irwrite, adrsrc;
    logic [1:0] resultsrc;
    logic       alusrca;
    logic [1:0] alusrcb, immsrc, regsrc;
    logic [2:0] aluctl;
    logic       fault;
  } vec_t;

  typedef struct packed {
    vec_t e;
    vec_t m;
  } sb_t;

  logic       clk, reset, MemRdy;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Mul4;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, Fault;
  logic [2:0] ALUControl;

  sb_t  sbq[$];
  sb_t  ent;
  vec_t act;
  int   errors = 0;
  int   checks = 0;
  int   cycle_no = 0;

  multicycle_decode dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Mul4(Mul4), .MemRdy(MemRdy),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Fault(Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, RegSrc, ALUControl, Fault};

  // Expected control word for one cycle of a given instruction phase
  function automatic vec_t model(input int ph, input logic [1:0] op, input logic [5:0] fn,
                                 input logic [3:0] rd, input logic [3:0] m4, input logic rdy);
    vec_t v;
    int   cmd;
    v = '0;
    cmd = int'(fn[4:1]);
    v.immsrc = op;
    v.regsrc = {op == 2'b01, op == 2'b10};
    case (ph)
      P_FETCH: begin
        v.alusrca = 1'b1; v.alusrcb = 2'b10; v.resultsrc = 2'b10;
        v.irwrite = rdy;  v.nextpc = rdy;
      end
      P_DECODE: begin v.alusrca = 1'b1; v.alusrcb = 2'b10; v.resultsrc = 2'b10; end
      P_MEMADR: v.alusrcb = 2'b01;
      P_MEMRD:  v.adrsrc = 1'b1;
      P_MEMWB:  begin v.resultsrc = 2'b01; v.regw = 1'b1; v.pcs = (rd == 4'd15); end
      P_MEMWR:  begin v.adrsrc = 1'b1; v.memw = 1'b1; end
      P_EXECR, P_EXECI: begin
        v.alusrcb = (ph == P_EXECI) ? 2'b01 : 2'b00;
        if (cmd == 4) v.aluctl = 3'd0;
        else if (cmd == 2) v.aluctl = 3'd1;
        else if (cmd == 0) v.aluctl = 3'd2;
        else if (cmd == 12) v.aluctl = 3'd3;
        else if (cmd == 1) v.aluctl = 3'd4;
        else v.aluctl = 3'd0;
`ifdef DECODE_MUL_EN
        if (ph == P_EXECR && cmd == 0 && m4 == 4'd9) v.aluctl = 3'd5;
`endif
        v.flagw[1] = fn[0];
        v.flagw[0] = fn[0] && (cmd == 4 || cmd == 2);
      end
      P_ALUWB:  begin v.regw = 1'b1; v.pcs = (rd == 4'd15); end
      P_BRANCH: begin v.alusrcb = 2'b01; v.resultsrc = 2'b10; v.pcs = 1'b1; end
      P_FAULT:  v.fault = 1'b1;
      default: ;
    endcase
    if (m4 == 4'hE) v.fault = v.fault;
    return v;
  endfunction

  // Monitor: compares every presented cycle against the oldest expectation
  always @(negedge clk) begin
    cycle_no++;
    if (sbq.size() > 0) begin
      ent = sbq.pop_front();
      checks++;
      if ((act & ent.m) !== (ent.e & ent.m)) begin
        errors++;
        $display("FAIL ctrl@cycle%0d: got %h required %h (mask %h)", cycle_no, act & ent.m, ent.e & ent.m, ent.m);
      end
    end
  end

  task automatic push_step(input vec_t e, input vec_t m);
    sbq.push_back({e, m});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    vec_t m;
    m = '0;
    m.pcs = 1'b1; m.regw = 1'b1; m.memw = 1'b1;
    reset = 1'b1;
    MemRdy = 1'($urandom_range(0, 1));
    push_step('0, m);
    reset = 1'b0;
  endtask

  task automatic fault_seq();
    for (int i = 0; i < 3; i++) begin
      MemRdy = 1'($urandom_range(0, 1));
      push_step(model(P_FAULT, Op, Funct, Rd, Mul4, MemRdy), '1);
    end
    reset_cycle();
  endtask

  task automatic do_cycle(input int ph, input logic rdy, input int abort, inout int cyc, output bit stop);
    stop = 1'b0;
    if (cyc == abort) begin
      reset_cycle();
      stop = 1'b1;
    end else begin
      MemRdy = rdy;
      push_step(model(ph, Op, Funct, Rd, Mul4, rdy), '1);
      cyc++;
    end
  endtask

  // Drives one instruction through the phases its opcode implies
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                           input logic [3:0] m4, input int fw, input int dw, input int abort);
    int phs[$];
    int cyc;
    int waits;
    bit stop;
    Op = op; Funct = fn; Rd = rd; Mul4 = m4;
    cyc = 0;
    phs.push_back(P_FETCH);
    phs.push_back(P_DECODE);
    case (op)
      2'b00: begin phs.push_back(fn[5] ? P_EXECI : P_EXECR); phs.push_back(P_ALUWB); end
      2'b01: begin
        phs.push_back(P_MEMADR);
        if (fn[0]) begin phs.push_back(P_MEMRD); phs.push_back(P_MEMWB); end
        else phs.push_back(P_MEMWR);
      end
      2'b10: phs.push_back(P_BRANCH);
      default: ;
    endcase
    foreach (phs[k]) begin
      if (phs[k] == P_FETCH || phs[k] == P_MEMRD || phs[k] == P_MEMWR) begin
        waits = (phs[k] == P_FETCH) ? fw : dw;
        for (int i = 0; i <= waits; i++) begin
          if (i == WAIT_LIMIT + 1) begin
            fault_seq();
            return;
          end
          do_cycle(phs[k], i == waits, abort, cyc, stop);
          if (stop) return;
        end
      end else begin
        do_cycle(phs[k], 1'($urandom_range(0, 1)), abort, cyc, stop);
        if (stop) return;
      end
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) begin
      r = int'($urandom_range(0, 2));
      return (r == 0) ? 15 : ((r == 1) ? 16 : 19);
    end
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [3:0] cmd;
    logic [5:0] fn;
    int r;
    reset = 1'b1; MemRdy = 1'b0; Op = '0; Funct = '0; Rd = '0; Mul4 = '0;
    @(posedge clk);
    #1;
    reset_cycle();
    run_instr(2'b00, 6'b001000, 4'd3,  4'd0, 0, 0, -1);
    run_instr(2'b00, 6'b100101, 4'd2,  4'd0, 1, 0, -1);
    run_instr(2'b01, 6'b011001, 4'd15, 4'd0, 0, 3, -1);
    run_instr(2'b01, 6'b011000, 4'd4,  4'd0, 0, 15, -1);
    run_instr(2'b01, 6'b011000, 4'd4,  4'd0, 0, 16, -1);
    run_instr(2'b10, 6'b100000, 4'd0,  4'd0, 0, 0, -1);
    run_instr(2'b00, 6'b001000, 4'd15, 4'd0, 0, 0, 2);
    run_instr(2'b00, 6'b000001, 4'd5,  4'd9, 0, 0, -1);
    run_instr(2'b00, 6'b001001, 4'd15, 4'd0, 0, 0, -1);
    run_instr(2'b11, 6'b000000, 4'd0,  4'd0, 2, 0, -1);
    run_instr(2'b00, 6'b011000, 4'd1,  4'd0, 16, 0, -1);
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 5));
      case (r)
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        4: cmd = 4'b0001;
        default: cmd = 4'($urandom);
      endcase
      fn = {1'($urandom), cmd, 1'($urandom)};
      run_instr(2'($urandom), fn,
                ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                ($urandom_range(0, 1) == 0) ? 4'd9 : 4'($urandom),
                pick_wait(), pick_wait(),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1);
    end
    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
